sobel_stream: RTL and testbench
===============================

# sobel_stream

Streaming 3x3 Sobel edge-magnitude engine for raster video. Accepts one pixel per cycle under a valid/ready handshake, keeps two previous lines in internal line buffers, and emits one gradient-magnitude pixel per accepted input pixel. Generalises the combinational Sobel core: parametrised pixel width, image size and output scaling, full Sobel weights in both directions, and frame/line framing with backpressure.

## Interface
- `PIX_W`, 8: pixel width in bits, input and output.
- `IMG_W`, 640: pixels per line. Sets line-buffer depth. Minimum 3.
- `IMG_H`, 480: lines per frame. Minimum 3.
- `SHIFT`, 2: right shift applied to |gx|+|gy| before saturation.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input pixel valid.
- `in_ready`  out  1  block can accept a pixel.
- `in_data`  in  PIX_W  input pixel, unsigned.
- `in_sof`  in  1  marks pixel (0,0) of a frame.
- `thr`  in  PIX_W  magnitude threshold; used only when the threshold feature is compiled in.
- `out_valid`  out  1  output pixel valid.
- `out_ready`  in  1  downstream can accept.
- `out_data`  out  PIX_W  edge magnitude.
- `out_sof`  out  1  output corresponds to input (0,0).
- `out_eol`  out  1  output corresponds to input column IMG_W-1.

## Operation
- Transfer happens when `valid && ready` on either port. `in_ready = !out_valid || out_ready`.
- Position counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance on each accepted pixel. `col` wraps to 0 and increments `row`. `row` wraps to 0 after IMG_H-1.
- An accepted pixel with `in_sof=1` is forced to position (0,0), and the counters continue from there. This resynchronises a frame that was cut short.
- There are two line buffers, LB1 (row-1) and LB2 (row-2), each IMG_W x PIX_W. On accept at column c, both are read at c, LB2[c] is written with LB1[c], and LB1[c] is written with `in_data`.
- The 3x3 window is formed from the two previous columns held in registers plus the new column {LB2[c], LB1[c], in_data}. The new pixel is the bottom-right tap.
  - p0..p8 are in row-major order, top-left to bottom-right.
- gx = (p2+2·p5+p8) − (p0+2·p3+p6).
- gy = (p0+2·p1+p2) − (p6+2·p7+p8).
- gx and gy are signed, PIX_W+4 bits. Absolute values are unsigned, PIX_W+3 bits. sum = (|gx|+|gy|) >> SHIFT, PIX_W+4 bits.
- sat = all-ones if any bit above PIX_W-1 is set, else sum[PIX_W-1:0].
- Window validity: if row<2 or col<2, `out_data` = 0. The output frame equals the input size, and the gradient lands on the window's bottom-right position, i.e. shifted by (+1,+1) from the window centre.
- Reset clears the counters, the window registers and all outputs. Line-buffer contents are not cleared; they are masked by the row<2 rule.

## Timing
- Latency is 1 cycle. A pixel accepted at edge N is presented with `out_valid=1` after edge N.
- When `out_valid && !out_ready`, `out_data`, `out_sof` and `out_eol` hold stable and `in_ready=0`.
- Throughput is 1 pixel/cycle with `out_ready` held high.
- Values after reset: `out_valid`=0, `out_data`=0, `out_sof`=0, `out_eol`=0, `in_ready`=1.
- Asserting `rst` mid-frame drops the pending output. The next accepted pixel is treated as (0,0) whether or not `in_sof` is set.
- If `rst` and `in_valid` are asserted together, the input is not accepted.

## Configuration
- `SOBEL_THRESHOLD_EN` defined: `out_data` = 0 when sat < `thr`, else sat. `thr` is sampled together with the pixel on accept.
- `SOBEL_THRESHOLD_EN` undefined: `out_data` = sat, and `thr` is ignored.

## Structure
- `sobel_pkg` holds:
  - width helper constants for the gradient (PIX_W+4) and for the absolute values (PIX_W+3);
  - the saturation function;
  - the window-index constants P0..P8.
- Sub-module `sobel_line_buffer` is a single-port read-before-write RAM, depth IMG_W, instantiated twice. Read data is available in the same cycle; it may be implemented as registers or as a RAM with a bypass.
- The kernel arithmetic stays inline, as a purely combinational function of the window.

## Test plan
Unless stated, the bench uses PIX_W=8, IMG_W=8, IMG_H=6, SHIFT=0, with the threshold feature undefined.
- Constant frame of 100, `out_ready`=1: 48 outputs, all 0. `out_sof` on output 0. `out_eol` on every 8th output.
- Vertical edge, columns 0–3 = 0 and columns 4–7 = 255: rows 2–5 give 255 at columns 4 and 5 and 0 elsewhere. Rows 0–1 give all 0.
- Same vertical edge with SHIFT=3 (sum 1020 >> 3 = 127): rows 2–5 give 127 at columns 4 and 5.
- Backpressure: drop `out_ready` for 5 cycles mid-line. `out_data` is held, `in_ready`=0, and no pixel is lost or duplicated; compare against the golden model.
- Threshold: build with `SOBEL_THRESHOLD_EN`, SHIFT=3, edge 0→80 (sum 320 >> 3 = 40):
  - `thr`=50: all outputs 0.
  - `thr`=30: edge columns give 40.
- Reset after 20 pixels, then a full frame with no `in_sof`: the output matches a clean frame, and the first output carries `out_sof`=1.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the streaming Sobel engine: gradient and
// absolute-value width helpers, window tap indices and output saturation.
package sobel_pkg;

  // Signed gradient width and unsigned absolute-value width for a pixel width.
  function automatic int grad_w(input int pix_w);
    return pix_w + 4;
  endfunction

  function automatic int abs_w(input int pix_w);
    return pix_w + 3;
  endfunction

  // Window taps in row-major order, top-left to bottom-right.
  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P3 = 3;
  localparam int P4 = 4;
  localparam int P5 = 5;
  localparam int P6 = 6;
  localparam int P7 = 7;
  localparam int P8 = 8;

  // Clamp v to the largest value representable in w bits.
  function automatic logic [31:0] saturate(input logic [31:0] v, input int w);
    logic [31:0] lim;
    lim = (32'd1 << w) - 32'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-port line buffer, read-before-write. Read data is combinational from
// the addressed entry, so a same-cycle write returns the old contents.
module sobel_line_buffer #(
  parameter int W     = 8,
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge-magnitude engine, one pixel per cycle, 1-cycle latency.
// Optional magnitude threshold compiled in with SOBEL_THRESHOLD_EN.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] thr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_sof,
  output logic             out_eol
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int GW  = grad_w(PIX_W);
  localparam int AWD = abs_w(PIX_W);

  logic [CW-1:0]    col, pcol;
  logic [RW-1:0]    row, prow;
  logic             accept;
  logic [PIX_W-1:0] lb1_rd, lb2_rd;
  logic [PIX_W-1:0] cl [3];
  logic [PIX_W-1:0] cm [3];
  logic [PIX_W-1:0] p  [9];
  logic signed [GW-1:0] gx, gy;
  logic [AWD-1:0]   ax, ay;
  logic [GW-1:0]    sum;
  logic [PIX_W-1:0] sat, mag;
  logic             win_ok;

  // Handshake: a transfer occurs on a port when valid && ready in the same
  // cycle; the input is stalled only while a held output is not being taken.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !rst;

  // in_sof resynchronises the position of the pixel it marks to (0,0).
  assign pcol = in_sof ? '0 : col;
  assign prow = in_sof ? '0 : row;

  sobel_line_buffer #(.W(PIX_W), .DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk(clk), .we(accept), .addr(pcol), .wdata(in_data), .rdata(lb1_rd)
  );

  sobel_line_buffer #(.W(PIX_W), .DEPTH(IMG_W), .AW(CW)) u_lb2 (
    .clk(clk), .we(accept), .addr(pcol), .wdata(lb1_rd), .rdata(lb2_rd)
  );

  always_comb begin
    p[P0] = cl[0];  p[P1] = cm[0];  p[P2] = lb2_rd;
    p[P3] = cl[1];  p[P4] = cm[1];  p[P5] = lb1_rd;
    p[P6] = cl[2];  p[P7] = cm[2];  p[P8] = in_data;
  end

  // The centre tap has zero weight in both kernels.
  logic unused_center;
  assign unused_center = ^p[P4];

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] v);
    return signed'(GW'(v));
  endfunction

  always_comb begin
    gx = (ext(p[P2]) + (ext(p[P5]) <<< 1) + ext(p[P8]))
       - (ext(p[P0]) + (ext(p[P3]) <<< 1) + ext(p[P6]));
    gy = (ext(p[P0]) + (ext(p[P1]) <<< 1) + ext(p[P2]))
       - (ext(p[P6]) + (ext(p[P7]) <<< 1) + ext(p[P8]));
    ax  = gx[GW-1] ? AWD'(-gx) : AWD'(gx);
    ay  = gy[GW-1] ? AWD'(-gy) : AWD'(gy);
    sum = (GW'(ax) + GW'(ay)) >> SHIFT;
    sat = PIX_W'(saturate(32'(sum), PIX_W));
  end

`ifdef SOBEL_THRESHOLD_EN
  assign mag = (sat < thr) ? '0 : sat;
`else
  assign mag = sat;
  logic unused_thr;
  assign unused_thr = ^thr;
`endif

  assign win_ok = (prow >= RW'(2)) && (pcol >= CW'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      cl        <= '{default: '0};
      cm        <= '{default: '0};
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (accept) begin
      if (pcol == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= (prow == RW'(IMG_H - 1)) ? '0 : prow + 1'b1;
      end else begin
        col <= pcol + 1'b1;
        row <= prow;
      end
      cl        <= cm;
      cm        <= '{lb2_rd, lb1_rd, in_data};
      out_valid <= 1'b1;
      out_data  <= win_ok ? mag : '0;
      out_sof   <= (pcol == '0) && (prow == '0);
      out_eol   <= (pcol == CW'(IMG_W - 1));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream: two instances (SHIFT=0 and SHIFT=3) share one input
// stream; outputs are scored against a frame-based reference model.
module tb_sobel_stream;

  localparam int PIX_W = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic out_ready = 1'b1;
  logic [PIX_W-1:0] in_data = '0;
  logic [PIX_W-1:0] thr = '0;

  logic in_ready0, out_valid0, out_sof0, out_eol0;
  logic in_ready1, out_valid1, out_sof1, out_eol1;
  logic [PIX_W-1:0] out_data0, out_data1;

  sobel_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_sof(in_sof), .thr(thr), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_sof(out_sof0), .out_eol(out_eol0)
  );

  sobel_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .SHIFT(3)) dut_s3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_sof(in_sof), .thr(thr), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .out_sof(out_sof1), .out_eol(out_eol1)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_got = 0;
  int stall_at = -1;
  int stall_left = 0;
  bit hold_off = 0;
  bit check_en = 1;
  int img [IMG_H][IMG_W];
  logic [PIX_W+1:0] exp_q[$];
  logic [PIX_W+1:0] exp3_q[$];

  // reference: direct 3x3 Sobel over the stored frame, {sof, eol, data}
  function automatic logic [PIX_W+1:0] model(input int r, input int c, input int sh);
    int p [9];
    int gx, gy, s;
    s = 0;
    if (r >= 2 && c >= 2) begin
      for (int k = 0; k < 9; k++) p[k] = img[r-2+k/3][c-2+k%3];
      gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
      gy = (p[0] + 2*p[1] + p[2]) - (p[6] + 2*p[7] + p[8]);
      if (gx < 0) gx = -gx;
      if (gy < 0) gy = -gy;
      s = (gx + gy) >> sh;
      if (s > 255) s = 255;
`ifdef SOBEL_THRESHOLD_EN
      if (s < int'(thr)) s = 0;
`endif
    end
    return {(r == 0 && c == 0), (c == IMG_W - 1), 8'(s)};
  endfunction

  // out_ready driver: stall windows and explicit hold
  initial begin
    forever begin
      @(posedge clk); #1;
      if (hold_off) out_ready = 1'b0;
      else if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
      else out_ready = 1'b1;
    end
  end

  // scoreboard / monitor, sampled on the falling edge
  bit held_v = 0;
  logic [PIX_W-1:0] held_d0, held_d1;
  logic held_s, held_e;
  always @(negedge clk) begin
    logic [PIX_W+1:0] e;
    if (rst) held_v = 0;
    else begin
      if (held_v) begin
        n_cmp++;
        if (out_valid0 !== 1'b1 || out_data0 !== held_d0 || out_sof0 !== held_s ||
            out_eol0 !== held_e || out_data1 !== held_d1) begin
          n_err++;
          $display("FAIL hold: got v=%b d=%0d/%0d sof=%b eol=%b need v=1 d=%0d/%0d sof=%b eol=%b",
                   out_valid0, out_data0, out_data1, out_sof0, out_eol0, held_d0, held_d1, held_s, held_e);
        end
      end
      if (out_valid0 && !out_ready) begin
        n_cmp++;
        if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
          n_err++;
          $display("FAIL in_ready_stall: got %b/%b need 0", in_ready0, in_ready1);
        end
        held_v = 1; held_d0 = out_data0; held_d1 = out_data1;
        held_s = out_sof0; held_e = out_eol0;
      end else held_v = 0;
      if (out_valid0 && out_ready) begin
        n_got++;
        if (check_en) begin
          n_cmp++;
          if (exp_q.size() == 0 || exp3_q.size() == 0 || out_valid1 !== 1'b1) begin
            n_err++;
            $display("FAIL extra_output: got d=%0d with no expected entry", out_data0);
          end else begin
            e = exp_q.pop_front();
            if ({out_sof0, out_eol0, out_data0} !== e) begin
              n_err++;
              $display("FAIL out_s0 #%0d: got sof=%b eol=%b d=%0d need sof=%b eol=%b d=%0d",
                       n_got, out_sof0, out_eol0, out_data0, e[9], e[8], e[7:0]);
            end
            e = exp3_q.pop_front();
            n_cmp++;
            if ({out_sof1, out_eol1, out_data1} !== e) begin
              n_err++;
              $display("FAIL out_s3 #%0d: got sof=%b eol=%b d=%0d need sof=%b eol=%b d=%0d",
                       n_got, out_sof1, out_eol1, out_data1, e[9], e[8], e[7:0]);
            end
          end
        end
        if (n_got == stall_at) begin stall_left = 5; stall_at = -1; end
      end
    end
  end

  // driver tasks (entered and left at posedge+1)
  task automatic push_px(input int d, input bit sof, output bit ok);
    in_valid = 1'b1; in_data = 8'(d); in_sof = sof; ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready0) begin @(posedge clk); #1; ok = 1; break; end
    end
    in_valid = 1'b0; in_sof = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for 100 cycles need 1");
    end
  endtask

  task automatic send_frame(input bit with_sof);
    bit ok;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        push_px(img[r][c], with_sof && r == 0 && c == 0, ok);
        if (ok && check_en) begin
          exp_q.push_back(model(r, c, 0));
          exp3_q.push_back(model(r, c, 3));
        end
      end
  endtask

  task automatic wait_drain(input string name, input int got_before);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || exp3_q.size() != 0); i++) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0 || exp3_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d outputs still missing need 0", name, exp_q.size());
      exp_q.delete(); exp3_q.delete();
    end
    n_cmp++;
    if (n_got - got_before != IMG_W * IMG_H) begin
      n_err++;
      $display("FAIL %s_count: got %0d outputs need %0d", name, n_got - got_before, IMG_W * IMG_H);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b/%b need 0", out_valid0, out_valid1); end
    n_cmp++; if (out_data0 !== 8'd0 || out_data1 !== 8'd0) begin n_err++; $display("FAIL rst_out_data: got %0d/%0d need 0", out_data0, out_data1); end
    n_cmp++; if (out_sof0 !== 1'b0 || out_sof1 !== 1'b0) begin n_err++; $display("FAIL rst_out_sof: got %b/%b need 0", out_sof0, out_sof1); end
    n_cmp++; if (out_eol0 !== 1'b0 || out_eol1 !== 1'b0) begin n_err++; $display("FAIL rst_out_eol: got %b/%b need 0", out_eol0, out_eol1); end
    n_cmp++; if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b/%b need 1", in_ready0, in_ready1); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_constant();
    int g;
    g = n_got;
    for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++) img[r][c] = 100;
    send_frame(1);
    wait_drain("constant", g);
  endtask

  task automatic test_vertical_edge();
    int g;
    g = n_got;
    for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++) img[r][c] = (c < 4) ? 0 : 255;
    send_frame(1);
    wait_drain("vedge", g);
  endtask

  task automatic test_backpressure();
    int g;
    g = n_got;
    for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++) img[r][c] = (r * 37 + c * 53 + 11) % 256;
    stall_at = n_got + 20;
    send_frame(1);
    wait_drain("backpressure", g);
  endtask

`ifdef SOBEL_THRESHOLD_EN
  task automatic test_threshold();
    int g;
    for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++) img[r][c] = (c < 4) ? 0 : 80;
    thr = 8'd50;
    g = n_got;
    send_frame(1);
    wait_drain("thr50", g);
    thr = 8'd30;
    g = n_got;
    send_frame(1);
    wait_drain("thr30", g);
    thr = 8'd0;
  endtask
`endif

  task automatic test_reset_mid_frame();
    bit ok;
    int g;
    check_en = 0;
    for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++) img[r][c] = (r * 91 + c * 29) % 256;
    for (int i = 0; i < 20; i++) push_px(img[i / IMG_W][i % IMG_W], i == 0, ok);
    repeat (2) @(posedge clk); #1;
    hold_off = 1;
    repeat (2) @(posedge clk); #1;
    push_px(77, 0, ok);
    // reset with a pending output and a valid input that must be ignored
    rst = 1'b1; in_valid = 1'b1; in_data = 8'd255;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_drop: got out_valid=%b in_ready=%b need 0/1", out_valid0, in_ready0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; hold_off = 0;
    check_en = 1;
    g = n_got;
    for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++) img[r][c] = (r * 19 + c * 71) % 256;
    send_frame(0);
    wait_drain("midrst", g);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_constant();
    test_vertical_edge();
    test_backpressure();
`ifdef SOBEL_THRESHOLD_EN
    test_threshold();
`endif
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
